// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation selects, RV32I opcode/funct fields and the
// issued-operation record passed from the issue stage toward the ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        illegal;
    } issue_t;

    // alt selects SUB/SRA variants; callers only raise it where those exist
    function automatic logic [3:0] f3_to_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        case (f3)
            F3_ADD_SUB: sel = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     sel = ALU_SLL;
            F3_SLT:     sel = ALU_SLT;
            F3_SLTU:    sel = ALU_SLTU;
            F3_XOR:     sel = ALU_XOR;
            F3_SRL_SRA: sel = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      sel = ALU_OR;
            F3_AND:     sel = ALU_AND;
            default:    sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I OP / OP-IMM decoder producing ALU select and operands.
// Anything not decodable is flagged illegal with ADD and zero operands.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic [3:0]  o_sel,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [4:0]  o_rd,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_is_alt;
    logic       w_is_shift;
    logic       w_unused_rs1_field;

    assign w_opcode   = i_instr[6:0];
    assign w_f3       = i_instr[14:12];
    assign w_f7       = i_instr[31:25];
    assign w_is_alt   = (w_f7 == FUNCT7_ALT);
    assign w_is_shift = (w_f3 == F3_SLL) || (w_f3 == F3_SRL_SRA);
    assign o_rd       = i_instr[11:7];
    assign w_unused_rs1_field = ^i_instr[19:15];

    // Field decode; illegal words fall through to the ADD/zero defaults
    always_comb begin
        o_sel     = ALU_ADD;
        o_a       = 32'd0;
        o_b       = 32'd0;
        o_illegal = 1'b1;
        if (w_opcode == OPC_OP) begin
            if ((w_f7 == FUNCT7_BASE) ||
                (w_is_alt && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SRL_SRA)))) begin
                o_illegal = 1'b0;
                o_sel     = f3_to_sel(w_f3, w_is_alt);
                o_a       = i_rs1_data;
                o_b       = i_rs2_data;
            end else begin
                o_illegal = 1'b1;
            end
        end else if (w_opcode == OPC_OP_IMM) begin
            // instr[31:25] only constrains shifts; elsewhere it is immediate
            if (!w_is_shift || (w_f7 == FUNCT7_BASE) ||
                (w_is_alt && (w_f3 == F3_SRL_SRA))) begin
                o_illegal = 1'b0;
                o_sel     = f3_to_sel(w_f3, w_is_alt && (w_f3 == F3_SRL_SRA));
                o_a       = i_rs1_data;
                if (w_is_shift) begin
                    o_b = {27'd0, i_instr[24:20]};
                end else begin
                    o_b = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end else begin
                o_illegal = 1'b1;
            end
        end else begin
            o_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes OP/OP-IMM and hands the result to the ALU through a
// registered valid/ready stage with a main register and one skid register.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [SEL_W-1:0] out_alu_sel,
    output logic [4:0]       out_rd,
    output logic             out_illegal
);

    issue_t w_dec;
    issue_t r_main;
    issue_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;
    logic   r_in_ready;

    logic   w_accept;
    logic   w_consume;
    logic   w_main_valid_nx;
    logic   w_skid_valid_nx;
    logic   w_main_from_skid;
    logic   w_main_from_in;
    logic   w_skid_from_in;

    alu_decoder u_dec (
        .i_instr    (in_instr),
        .i_rs1_data (in_rs1_data),
        .i_rs2_data (in_rs2_data),
        .o_sel      (w_dec.sel),
        .o_a        (w_dec.a),
        .o_b        (w_dec.b),
        .o_rd       (w_dec.rd),
        .o_illegal  (w_dec.illegal)
    );

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_main_valid && out_ready;

    // Occupancy / steering; flush overrides every transfer
    always_comb begin
        w_main_valid_nx  = r_main_valid;
        w_skid_valid_nx  = r_skid_valid;
        w_main_from_skid = 1'b0;
        w_main_from_in   = 1'b0;
        w_skid_from_in   = 1'b0;
        if (flush) begin
            w_main_valid_nx = 1'b0;
            w_skid_valid_nx = 1'b0;
        end else if (w_consume && r_skid_valid) begin
            w_main_from_skid = 1'b1;
            w_main_valid_nx  = 1'b1;
            w_skid_from_in   = w_accept;
            w_skid_valid_nx  = w_accept;
        end else if (w_accept && (!r_main_valid || w_consume)) begin
            w_main_from_in  = 1'b1;
            w_main_valid_nx = 1'b1;
        end else if (w_accept) begin
            w_skid_from_in  = 1'b1;
            w_skid_valid_nx = 1'b1;
        end else if (w_consume) begin
            w_main_valid_nx = 1'b0;
        end else begin
            w_main_valid_nx = r_main_valid;
        end
    end

    // Valid flags; in_ready is registered so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_in_ready   <= !w_skid_valid_nx;
        end
    end

    // Payload registers; held unchanged unless a transfer targets them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_from_skid) begin
                r_main <= r_skid;
            end else if (w_main_from_in) begin
                r_main <= w_dec;
            end
            if (w_skid_from_in) begin
                r_skid <= w_dec;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_valid;
    assign out_a       = r_main.a;
    assign out_b       = r_main.b;
    assign out_alu_sel = r_main.sel;
    assign out_rd      = r_main.rd;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage: a 2-deep FIFO model fed by a rule-based
// decoder is compared with the DUT every cycle, plus literal spot checks.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alu_sel;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];

    alu_issue_stage #(.XLEN(32), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_sel(out_alu_sel),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode written straight from the ISA rules
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] r1,
                                        input logic [31:0] r2);
        exp_t e;
        int   tbl[8];
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        bit   alt, shift, legal;
        tbl   = '{0, 7, 5, 6, 4, 8, 3, 2};
        op    = ins[6:0];
        f7    = ins[31:25];
        f3    = ins[14:12];
        alt   = (f7 == 7'h20);
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        e.rd  = ins[11:7];
        e.a   = 32'd0;
        e.b   = 32'd0;
        e.sel = 4'd0;
        e.ill = 1'b1;
        if (op == 7'h33) begin
            legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
            if (legal) begin
                e.ill = 1'b0;
                e.sel = 4'(tbl[f3] + ((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0));
                e.a   = r1;
                e.b   = r2;
            end
        end else if (op == 7'h13) begin
            legal = !shift || (f7 == 7'h00) || (alt && f3 == 3'd5);
            if (legal) begin
                e.ill = 1'b0;
                e.sel = 4'(tbl[f3] + ((alt && f3 == 3'd5) ? 1 : 0));
                e.a   = r1;
                e.b   = shift ? {27'd0, ins[24:20]} : 32'($signed(ins[31:20]));
            end
        end
        return e;
    endfunction

    task automatic check_all();
        exp_t e;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
        if (q.size() > 0) begin
            e = q[0];
            chk("out_a", out_a, e.a);
            chk("out_b", out_b, e.b);
            chk("out_alu_sel", {28'd0, out_alu_sel}, {28'd0, e.sel});
            chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
        end
    endtask

    // One clock: drive at negedge, update model at posedge, compare at next negedge
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ordy, input logic fl,
                         output logic acc);
        logic con;
        in_valid = v; in_instr = ins; in_rs1_data = r1; in_rs2_data = r2;
        out_ready = ordy; flush = fl;
        @(posedge clk);
        acc = !fl && v && (q.size() < 2);
        con = !fl && ordy && (q.size() > 0);
        if (fl) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(ins, r1, r2));
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] f7;
        int k, s;
        k = $urandom_range(0, 9);
        s = $urandom_range(0, 9);
        f7 = (s < 6) ? 7'h00 : (s < 9) ? 7'h20 : 7'($urandom);
        if (k < 4)
            return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
        else if (k < 8)
            return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h13};
        else
            return 32'($urandom);
    endfunction

    logic        acc;
    int          idx;
    exp_t        pin;
    logic [31:0] bp_instr [4];

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0;

        pin = ref_decode(32'hFFB00293, 32'd0, 32'd0);
        chk("ref_addi_b", pin.b, 32'hFFFFFFFB);
        pin = ref_decode(32'h4020D313, 32'd0, 32'd0);
        chk("ref_srai_sel", {28'd0, pin.sel}, 32'd9);
        pin = ref_decode(32'h022081B3, 32'd7, 32'd8);
        chk("ref_mul_ill", {31'd0, pin.ill}, 32'd1);

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_out_sel", {28'd0, out_alu_sel}, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_ill", {31'd0, out_illegal}, 32'd0);
        rst_n = 1'b1;
        check_all();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed decodes, one per cycle with out_ready held high
        cycle(1'b1, 32'h002081B3, 32'd10, 32'd20, 1'b1, 1'b0, acc);
        chk("add_a", out_a, 32'd10);
        chk("add_b", out_b, 32'd20);
        chk("add_sel", {28'd0, out_alu_sel}, 32'd0);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        cycle(1'b1, 32'h402081B3, 32'd10, 32'd20, 1'b1, 1'b0, acc);
        chk("sub_sel", {28'd0, out_alu_sel}, 32'd1);
        cycle(1'b1, 32'hFFB00293, 32'd0, 32'd99, 1'b1, 1'b0, acc);
        chk("addi_b", out_b, 32'hFFFFFFFB);
        chk("addi_rd", {27'd0, out_rd}, 32'd5);
        cycle(1'b1, 32'h4020D313, 32'd64, 32'd99, 1'b1, 1'b0, acc);
        chk("srai_b", out_b, 32'd2);
        chk("srai_sel", {28'd0, out_alu_sel}, 32'd9);
        chk("srai_rd", {27'd0, out_rd}, 32'd6);
        cycle(1'b1, 32'h022081B3, 32'd5, 32'd6, 1'b1, 1'b0, acc);
        chk("mul_ill", {31'd0, out_illegal}, 32'd1);
        chk("mul_a", out_a, 32'd0);
        cycle(1'b1, 32'h0000A183, 32'd5, 32'd6, 1'b1, 1'b0, acc);
        chk("load_ill", {31'd0, out_illegal}, 32'd1);
        chk("load_b", out_b, 32'd0);
        cycle(1'b1, 32'h40209113, 32'd5, 32'd6, 1'b1, 1'b0, acc);
        chk("slli_alt_ill", {31'd0, out_illegal}, 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

        // Back-pressure: 4 ADDs, downstream stalled for 3 cycles
        for (int i = 0; i < 4; i++) bp_instr[i] = {7'h00, 5'd2, 5'd1, 3'd0, 5'(i + 8), 7'h33};
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, bp_instr[idx], 32'(100 + idx), 32'd1, 1'b0, 1'b0, acc);
            if (acc) idx++;
            if (c == 1) chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            if (c >= 1) chk("bp_hold_a", out_a, 32'd100);
        end
        for (int c = 0; c < 10 && idx < 4; c++) begin
            cycle(1'b1, bp_instr[idx], 32'(100 + idx), 32'd1, 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd4);
        repeat (3) cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

        // Flush with main and skid full and a new op offered
        cycle(1'b1, 32'h002081B3, 32'd1, 32'd1, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h002081B3, 32'd2, 32'd2, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h002081B3, 32'd3, 32'd3, 1'b1, 1'b1, acc);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

        // Random traffic with occasional flush
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, acc);
        end

        // Asynchronous reset in the middle of traffic
        cycle(1'b1, 32'h002081B3, 32'd7, 32'd8, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h002081B3, 32'd9, 32'd8, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_a", out_a, 32'd0);
        chk("arst_out_b", out_b, 32'd0);
        chk("arst_out_rd", {27'd0, out_rd}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'h002081B3, 32'd11, 32'd22, 1'b1, 1'b0, acc);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_a", out_a, 32'd11);
        repeat (2) cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU operand interface: decodes RISC-V RV32I OP (R-type) and OP-IMM (I-type) instructions into alu_sel, operand A and operand B.
- Registers the results toward the ALU through a valid/ready pipeline stage with a 2-entry skid buffer.
- Sits between register-file read and the combinational ALU in the execute stage.

Parameters:
XLEN, 32, operand/data width (only 32 supported)
SEL_W, 4, alu_sel width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; drops all buffered entries
in_valid  in  1  instruction/operands valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction word
in_rs1_data  in  XLEN  rs1 register value
in_rs2_data  in  XLEN  rs2 register value
out_valid  out  1  issued op valid
out_ready  in  1  downstream accepts
out_a  out  XLEN  ALU operand a
out_b  out  XLEN  ALU operand b
out_alu_sel  out  4  ALU operation select
out_rd  out  5  destination register (instr[11:7])
out_illegal  out  1  instruction not decodable as OP/OP-IMM

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_a=0, out_b=0, out_alu_sel=0000, out_rd=0, out_illegal=0, skid empty. in_ready=1 from the first cycle after reset.
- alu_sel encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- Decode for opcode 0110011 (R-type), selected by funct3:
  - 000: ADD, or SUB if funct7=0100000
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR
  - 101: SRL, or SRA if funct7=0100000
  - 110: OR; 111: AND
  - Operands: a=rs1_data, b=rs2_data.
  - Legal funct7: 0000000 for all funct3; 0100000 only with funct3 000 or 101. Anything else is illegal.
- Decode for opcode 0010011 (I-type), same funct3 map, with these differences:
  - funct3 000 is always ADD.
  - b = sign-extended instr[31:20].
  - For shifts (001, 101), b = zero-extended shamt instr[24:20].
  - instr[31:25] must be 0000000, or 0100000 for funct3=101 only; otherwise illegal.
- Any other opcode is illegal.
- Illegal entries are still issued with out_illegal=1, alu_sel=ADD, a=0, b=0, rd=instr[11:7].
- Latency: exactly 1 cycle from accepted input (in_valid && in_ready) to out_valid, when the output register is empty or draining.
- Buffering: main output register plus one skid register.
  - in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
  - On accept: if main is empty, or main is being consumed (out_valid && out_ready), the entry loads main. Otherwise it loads skid.
  - When main is consumed and skid is valid, skid moves to main in the same edge; a simultaneous new accept then goes to skid.
  - Sustained throughput is 1 op/cycle. Order is strictly FIFO; no entry is dropped or duplicated.
- Output data holds stable while out_valid && !out_ready.
- flush: at the next edge main and skid are both invalidated and any same-cycle accept is discarded; in_ready=1 afterwards. flush has priority over all transfers.
- Reset mid-operation: all buffered entries are lost immediately; outputs return to reset values asynchronously.

Decomposition:
- Shared package alu_pkg:
  - ALU_ADD..ALU_SRA localparams (4-bit)
  - OPC_OP=0110011, OPC_OP_IMM=0010011
  - funct3 constants; FUNCT7_BASE=0000000, FUNCT7_ALT=0100000
  - The same package is consumed by the alu module.
- One natural sub-module: alu_decoder, purely combinational (instr, rs1, rs2 -> sel, a, b, rd, illegal). The issue stage wraps it with the skid/handshake logic.

Test Plan:
- add x3,x1,x2 = 0x002081B3, rs1=10, rs2=20, out_ready=1 -> next cycle out_valid=1, a=10, b=20, sel=0000, rd=3, illegal=0.
- sub 0x402081B3 -> sel=0001. addi x5,x0,-5 = 0xFFB00293 -> b=0xFFFFFFFB, sel=0000, rd=5. srai x6,x1,2 = 0x4020D313 -> b=2, sel=1001, rd=6.
- mul 0x022081B3 and a load opcode 0x0000A183 -> illegal=1, sel=0000, a=0, b=0; slli with instr[31:25]=0100000 -> illegal=1.
- Back-pressure: in_valid=1 with 4 distinct ADDs back-to-back, out_ready=0 for 3 cycles -> 2 accepted, in_ready=0 on the cycle after the 2nd accept, outputs stable. Raising out_ready drains all 4 in order with no bubbles once flowing.
- flush asserted while main and skid are both full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed ops never appear.
- rst_n pulled low mid-stream (asynchronously, between edges) -> out_valid=0 and outputs zero immediately. After release, the first accepted op appears after exactly 1 cycle.
